potential_decay_array: RTL

//  Per-timestep membrane-potential decay engine for a bank of NUM_NEURONS LIF neurons.

---
 rtl/potential_decay_array.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/potential_decay_array.sv
// Membrane-potential decay bank: sweeps all neurons on clear, exponent-shift decay.
// Optional POTENTIAL_DECAY_ADD_EN enables the x0.75 rate (x/2 + x/4) via an FP adder.
module potential_decay_array #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              init_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_potential,
  input  logic [3:0]        init_rate,
  input  logic [1:0]        init_model,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_potential,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              last;

  logic [31:0] pot_mem   [NUM_NEURONS];
  logic [3:0]  rate_mem  [NUM_NEURONS];
  logic [1:0]  model_mem [NUM_NEURONS];

  logic [31:0] cur_pot;
  logic [3:0]  cur_rate;
  logic [1:0]  cur_model;
  logic [1:0]  k;
  logic [31:0] decayed;

  // Exponent shift; anything that would go denormal flushes to signed zero.
  function automatic logic [31:0] shift_decay(input logic [31:0] x,
                                              input logic [1:0]  s);
    if (x[30:23] == 8'hFF) return x;
    if (x[30:23] <= {6'd0, s}) return {x[31], 31'b0};
    return {x[31], x[30:23] - {6'd0, s}, x[22:0]};
  endfunction

  assign last      = (idx == LAST);
  assign acc_ready = !busy;

  always_comb begin
    k = 2'd0;
    case (cur_rate)
      4'b0010: k = 2'd1;
      4'b0100: k = 2'd2;
      4'b1000: k = 2'd3;
      default: k = 2'd0;
    endcase
  end

`ifdef POTENTIAL_DECAY_ADD_EN
  logic [31:0] half, quarter, add_sum;
  logic        add_exc;

  assign half    = shift_decay(cur_pot, 2'd1);
  assign quarter = shift_decay(cur_pot, 2'd2);

  Addition_Subtraction u_add (
    .a_operand  (half),
    .b_operand  (quarter),
    .AddBar_Sub (1'b0),
    .Exception  (add_exc),
    .result     (add_sum)
  );
`endif

  always_comb begin
    decayed = shift_decay(cur_pot, k);
    if (cur_model != 2'b00) decayed = cur_pot;
`ifdef POTENTIAL_DECAY_ADD_EN
    else if (cur_rate == 4'b0011) decayed = add_sum;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = last ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // busy trails the FSM by one cycle on the way out of a sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_potential <= '0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      cur_pot       <= '0;
      cur_rate      <= 4'b0001;
      cur_model     <= 2'b00;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (clear && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          busy <= clear;
          idx  <= '0;
        end
        READ: begin
          cur_pot   <= pot_mem[idx];
          cur_rate  <= rate_mem[idx];
          cur_model <= model_mem[idx];
        end
        WRITE: begin
          out_valid     <= 1'b1;
          out_addr      <= idx;
          out_potential <= decayed;
          done          <= last;
          idx           <= last ? '0 : idx + ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_mem[i]   <= '0;
        rate_mem[i]  <= 4'b0001;
        model_mem[i] <= 2'b00;
      end
    end else begin
      if (acc_valid && !busy) pot_mem[acc_addr] <= acc_potential;
      // init written last so it wins an address collision
      if (init_en && !busy) begin
        pot_mem[init_addr]   <= init_potential;
        rate_mem[init_addr]  <= init_rate;
        model_mem[init_addr] <= init_model;
      end
      if (state == WRITE) pot_mem[idx] <= decayed;
    end
  end

endmodule
